// File: rtl/z80_bus_ctrl.sv
// Z80 CPU-side bus interface unit.
// Turns single-beat core requests (opcode fetch, memory read, memory write)
// into T-state sequenced machine cycles. Wait states come from WAIT_L. The
// M1 refresh is run here, and this block owns the R register.
// Every strobe and bus enable is a flop: the comb block works out what the
// *next* cycle should show, and the flops present it for that whole cycle.
module z80_bus_ctrl #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [7:0]  i_reg,
    input  logic        r_load,
    input  logic [7:0]  r_wdata,
    output logic [7:0]  r_out,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    input  logic        WAIT_L,
    output logic        MREQ_L,
    output logic        RD_L,
    output logic        WR_L,
    output logic        M1_L,
    output logic        RFSH_L,
    inout  wire  [15:0] addr_bus,
    inout  wire  [7:0]  data_bus
);

    localparam logic [1:0] TY_FETCH = 2'b00;
    localparam logic [1:0] TY_RD    = 2'b01;
    localparam logic [1:0] TY_WR    = 2'b10;
    localparam logic [1:0] TY_ILL   = 2'b11;
    localparam logic [7:0] TIMEOUT  = 8'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_type, w_type;
    logic [15:0] r_addr, w_addr;
    logic [7:0]  r_dout, r_cnt, w_cnt, r_r, r_rdata;
    logic        r_mreq, r_rd, r_wr, r_m1, r_rfsh, r_aoe, r_doe;
    logic        w_mreq, w_rd, w_wr, w_m1, w_rfsh, w_aoe, w_doe;
    logic        r_rsp_valid, r_rsp_err, w_rsp_valid, w_rsp_err;
    logic        w_accept, w_cap, w_rinc;

    // Next state and the bus values for the cycle being entered
    always_comb begin
        w_state     = r_state;
        w_type      = r_type;
        w_cnt       = r_cnt;
        w_accept    = 1'b0;
        w_cap       = 1'b0;
        w_rinc      = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_mreq      = 1'b1;
        w_rd        = 1'b1;
        w_wr        = 1'b1;
        w_m1        = 1'b1;
        w_rfsh      = 1'b1;
        w_aoe       = 1'b0;
        w_doe       = 1'b0;
        w_addr      = r_addr;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_type == TY_ILL) begin
                        // Illegal type: no bus cycle, just an error response
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_type   = req_type;
                        w_state  = S_T1;
                    end
                end
            end
            S_T1: begin
                w_state = S_T2;
                w_cnt   = 8'd0;
            end
            S_T2, S_TW: begin
                if (WAIT_L) begin
                    // The opcode is taken on the last read edge before refresh
                    w_state = S_T3;
                    w_cap   = (r_type == TY_FETCH);
                end else if (r_state == S_TW && r_cnt == TIMEOUT) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_state = S_TW;
                    w_cnt   = r_cnt + 8'd1;
                end
            end
            S_T3: begin
                if (r_type == TY_FETCH) begin
                    w_state = S_T4;
                end else begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b1;
                    w_cap       = (r_type == TY_RD);
                end
            end
            S_T4: begin
                w_state     = S_IDLE;
                w_rsp_valid = 1'b1;
                w_rinc      = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase

        case (w_state)
            S_T1: begin
                w_aoe  = 1'b1;
                w_addr = req_addr;
                w_mreq = 1'b0;
                w_rd   = (w_type == TY_WR);
                w_m1   = (w_type != TY_FETCH);
                w_doe  = (w_type == TY_WR);
            end
            S_T2, S_TW: begin
                w_aoe  = 1'b1;
                w_mreq = 1'b0;
                w_rd   = (w_type == TY_WR);
                w_wr   = (w_type != TY_WR);
                w_m1   = (w_type != TY_FETCH);
                w_doe  = (w_type == TY_WR);
            end
            S_T3: begin
                w_aoe  = 1'b1;
                w_mreq = 1'b0;
                if (w_type == TY_FETCH) begin
                    w_addr = {i_reg, r_r};
                    w_rfsh = 1'b0;
                end else begin
                    w_rd  = (w_type == TY_WR);
                    w_wr  = (w_type != TY_WR);
                    w_doe = (w_type == TY_WR);
                end
            end
            S_T4: begin
                w_aoe  = 1'b1;
                w_rfsh = 1'b0;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) r_state <= S_IDLE;
        else        r_state <= w_state;
    end

    // Registered strobes, bus drives, latched request and wait counter
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_mreq <= 1'b1;
            r_rd   <= 1'b1;
            r_wr   <= 1'b1;
            r_m1   <= 1'b1;
            r_rfsh <= 1'b1;
            r_aoe  <= 1'b0;
            r_doe  <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
            r_type <= TY_FETCH;
            r_cnt  <= '0;
        end else begin
            r_mreq <= w_mreq;
            r_rd   <= w_rd;
            r_wr   <= w_wr;
            r_m1   <= w_m1;
            r_rfsh <= w_rfsh;
            r_aoe  <= w_aoe;
            r_doe  <= w_doe;
            r_addr <= w_addr;
            r_cnt  <= w_cnt;
            if (w_accept) begin
                r_type <= req_type;
                r_dout <= req_wdata;
            end
        end
    end

    // Response pulse, captured read byte and R (a load wins over the refresh bump)
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_r         <= '0;
        end else begin
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            if (w_cap) r_rdata <= data_bus;
            if (r_load)      r_r <= r_wdata;
            else if (w_rinc) r_r <= {r_r[7], r_r[6:0] + 7'd1};
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rdata;
    assign r_out     = r_r;
    assign MREQ_L    = r_mreq;
    assign RD_L      = r_rd;
    assign WR_L      = r_wr;
    assign M1_L      = r_m1;
    assign RFSH_L    = r_rfsh;
    assign addr_bus  = r_aoe ? r_addr : 'z;
    assign data_bus  = r_doe ? r_dout : 'z;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: directed cases, then randomized requests against
// a transaction-level model. A monitor pops expected responses from a queue.
module tb_z80_bus_ctrl;

    localparam int TO = 4;
    localparam logic [1:0] FETCH = 2'b00, RD = 2'b01, WR = 2'b10, ILL = 2'b11;

    logic        clk = 1'b0, rst_L = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0, i_reg = 8'h0, r_wdata = 8'h0;
    logic        r_load = 1'b0;
    logic [7:0]  r_out, rsp_data;
    logic        rsp_valid, rsp_err;
    logic        WAIT_L = 1'b1;
    logic        MREQ_L, RD_L, WR_L, M1_L, RFSH_L;
    wire  [15:0] addr_bus;
    wire  [7:0]  data_bus;
    logic        probe = 1'b0;

    logic [7:0] mem [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] m_r = 8'h00, m_data = 8'h00;
    int cyc = 0;
    int n_chk = 0, n_pass = 0;

    typedef struct { logic [7:0] data; logic err; logic [7:0] r; int cyc; } exp_t;
    typedef struct { logic [4:0] s; logic [15:0] a; logic [7:0] d; } smp_t;
    exp_t q[$];
    smp_t trace[$];

    z80_bus_ctrl #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_L(rst_L),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .i_reg(i_reg), .r_load(r_load), .r_wdata(r_wdata), .r_out(r_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .WAIT_L(WAIT_L), .MREQ_L(MREQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .M1_L(M1_L), .RFSH_L(RFSH_L),
        .addr_bus(addr_bus), .data_bus(data_bus)
    );

    // Memory answers any active read; the probe pulls both buses to zero
    // so a released bus reads back 0 and a still-driven one does not.
    assign addr_bus = probe ? 16'h0000 : 'z;
    assign data_bus = (!MREQ_L && !RD_L) ? mem[addr_bus] : (probe ? 8'h00 : 'z);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fill(input int i);
        return 8'((i * 37) ^ (i >> 8) ^ 8'h5C);
    endfunction

    // Memory store: any posedge with a write strobe asserted stores the byte
    initial begin : mem_proc
        for (int i = 0; i < 65536; i++) mem[i] = fill(i);
        mem[16'h0000] = 8'h2A;
        mem[16'h00BB] = 8'hEF;
        forever begin
            @(posedge clk);
            if (!MREQ_L && !WR_L) mem[addr_bus] = data_bus;
        end
    end

    always @(negedge clk) trace.push_back('{{MREQ_L, RD_L, WR_L, M1_L, RFSH_L}, addr_bus, data_bus});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Monitor: every response must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_L && rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            else begin
                e = q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("r_out", 32'(r_out), 32'(e.r));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 20 && !req_ready; k++) begin @(posedge clk); #1; end
        chk("req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [7:0] wd, input int w);
        exp_t e;
        int lat, a0;
        wait_ready();
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        a0 = cyc;
        trace.delete();
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom); req_type = 2'($urandom);
        e.err = 1'b0;
        // The write strobe is asserted from T2 on, so memory takes the byte
        // even when the cycle later times out.
        if (t == WR) ref_mem[a] = wd;
        if (t == ILL) begin
            lat = 1; e.err = 1'b1;
        end else if (w > TO) begin
            lat = 3 + TO; e.err = 1'b1;
        end else begin
            lat = (t == FETCH) ? 5 + w : 4 + w;
            if (t != WR) m_data = ref_mem[a];
            if (t == FETCH) m_r = {m_r[7], m_r[6:0] + 7'd1};
        end
        e.data = m_data; e.r = m_r; e.cyc = a0 + lat - 1;
        q.push_back(e);
        if (t != ILL && w > 0) begin
            @(posedge clk); #1; WAIT_L = 1'b0;
            repeat (w) @(posedge clk);
            #1; WAIT_L = 1'b1;
        end
        for (int k = 0; k < 400 && q.size() != 0; k++) begin @(posedge clk); #1; end
        chk("rsp_arrived", 32'(q.size()), 32'd0);
        if (q.size() != 0) q.delete();
    endtask

    task automatic rload(input logic [7:0] v);
        r_load = 1'b1; r_wdata = v;
        @(posedge clk); #1;
        r_load = 1'b0;
        m_r = v;
        chk("r_load", 32'(r_out), 32'(v));
    endtask

    task automatic tchk(input string nm, input int idx, input logic [4:0] s,
                        input logic ca, input logic [15:0] a, input logic cd, input logic [7:0] d);
        if (idx >= trace.size()) chk({nm, "_len"}, 32'(trace.size()), 32'(idx + 1));
        else begin
            chk({nm, "_strb"}, 32'(trace[idx].s), 32'(s));
            if (ca) chk({nm, "_addr"}, 32'(trace[idx].a), 32'(a));
            if (cd) chk({nm, "_data"}, 32'(trace[idx].d), 32'(d));
        end
    endtask

    task automatic chk_released(input string nm);
        probe = 1'b1; #1;
        chk({nm, "_addr_z"}, 32'(addr_bus), 32'd0);
        chk({nm, "_data_z"}, 32'(data_bus), 32'd0);
        probe = 1'b0; #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 65536; i++) ref_mem[i] = fill(i);
        ref_mem[16'h0000] = 8'h2A;
        ref_mem[16'h00BB] = 8'hEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({MREQ_L, RD_L, WR_L, M1_L, RFSH_L}), 32'h1F);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_L = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_r", 32'(r_out), 32'd0);
        chk_released("rst");
        @(posedge clk); #1;

        // Opcode fetch from 0x0000
        i_reg = 8'h00;
        issue(FETCH, 16'h0000, 8'h00, 0);
        tchk("f_t1", 0, 5'b00101, 1'b1, 16'h0000, 1'b0, 8'h00);
        tchk("f_t2", 1, 5'b00101, 1'b1, 16'h0000, 1'b0, 8'h00);
        tchk("f_t3", 2, 5'b01110, 1'b1, 16'h0000, 1'b0, 8'h00);
        tchk("f_t4", 3, 5'b11110, 1'b1, 16'h0000, 1'b0, 8'h00);
        tchk("f_idle", 4, 5'b11111, 1'b0, 16'h0000, 1'b0, 8'h00);

        // Read with three wait states
        issue(RD, 16'h00BB, 8'h00, 3);
        tchk("rd_tw", 4, 5'b00111, 1'b1, 16'h00BB, 1'b0, 8'h00);

        // Write then read back
        issue(WR, 16'h0010, 8'h5A, 0);
        tchk("wr_t1", 0, 5'b01111, 1'b1, 16'h0010, 1'b1, 8'h5A);
        tchk("wr_t2", 1, 5'b01011, 1'b1, 16'h0010, 1'b1, 8'h5A);
        tchk("wr_t3", 2, 5'b01011, 1'b1, 16'h0010, 1'b1, 8'h5A);
        issue(RD, 16'h0010, 8'h00, 0);

        // R wrap of the low seven bits, bit 7 kept
        rload(8'hFF);
        i_reg = 8'h3C;
        issue(FETCH, 16'h0123, 8'h00, 1);
        tchk("rw_t3", 3, 5'b01110, 1'b1, 16'h3CFF, 1'b0, 8'h00);
        tchk("rw_t4", 4, 5'b11110, 1'b1, 16'h3CFF, 1'b0, 8'h00);

        // Wait timeout on a read, then on a fetch (R must not move)
        issue(RD, 16'h0040, 8'h00, 10);
        tchk("to_rsp", 2 + TO, 5'b11111, 1'b0, 16'h0000, 1'b0, 8'h00);
        chk_released("to");
        issue(FETCH, 16'h0055, 8'h00, 6);

        // Illegal type: error response, no strobes
        issue(ILL, 16'h1234, 8'h99, 0);
        tchk("ill", 0, 5'b11111, 1'b0, 16'h0000, 1'b0, 8'h00);

        // Randomized traffic over a small address window
        for (int n = 0; n < 40; n++) begin
            int sel, w;
            logic [1:0] t;
            sel = int'($urandom_range(0, 9));
            t = (sel < 3) ? FETCH : (sel < 6) ? RD : (sel < 9) ? WR : ILL;
            w = ($urandom_range(0, 7) == 0) ? 5 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            i_reg = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rload(8'($urandom));
            issue(t, 16'h0100 + 16'($urandom_range(0, 15)), 8'($urandom), w);
        end

        // Reset in the middle of a write wait state
        wait_ready();
        req_valid = 1'b1; req_type = WR; req_addr = 16'h0010; req_wdata = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0; WAIT_L = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("mr_wr_active", 32'(WR_L), 32'd0);
        rst_L = 1'b0; #1;
        chk("mr_mreq", 32'(MREQ_L), 32'd1);
        chk("mr_wr", 32'(WR_L), 32'd1);
        chk_released("mr");
        repeat (3) @(posedge clk);
        #1; WAIT_L = 1'b1; rst_L = 1'b1;
        m_r = 8'h00; m_data = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mr_r", 32'(r_out), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd1);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
